// File: rtl/load_extend_ctrl.sv
// Load sequencer: issues one or two word reads, selects the byte/half lane,
// sign/zero-extends it and returns the result with a one-cycle done pulse.
module load_extend_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ld_req,
  input  logic [31:0] i_ld_addr,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_signed,
  output logic        o_ld_busy,
  output logic        o_ld_done,
  output logic        o_ld_err,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_ld_data_hi,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ0, S_REQ1, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_addr;
  logic [1:0]      r_size;
  logic            r_signed;
  logic [TO_W-1:0] r_cnt;
  logic [31:0]     r_ld_data;
  logic [31:0]     r_ld_data_hi;
  logic            r_ld_err;

  logic            w_misaligned;
  logic            w_expire;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ext;
  logic [31:0]     w_base;

  assign w_expire = (r_cnt == TO_W'(TIMEOUT - 1));
  assign w_base   = {r_addr[31:2], 2'b00};

  always_comb begin
    w_misaligned = 1'b0;
    case (i_ld_size)
      2'b01:   w_misaligned = i_ld_addr[0];
      2'b10:   w_misaligned = (i_ld_addr[1:0] != 2'b00);
      2'b11:   w_misaligned = (i_ld_addr[2:0] != 3'b000);
      default: w_misaligned = 1'b0;
    endcase
  end

  // Lane select and extension operate on the latched address, not the live input.
  always_comb begin
    w_byte = i_mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = i_mem_rdata[{r_addr[1], 4'b0000} +: 16];
    w_ext  = i_mem_rdata;
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_mem_req    = 1'b0;
    o_mem_addr   = 32'h0;
    o_ld_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ld_req) begin
          w_state_next = w_misaligned ? S_DONE : S_REQ0;
        end
      end
      S_REQ0: begin
        o_mem_req  = 1'b1;
        o_mem_addr = w_base;
        if (i_mem_ack) begin
          w_state_next = (r_size == 2'b11) ? S_REQ1 : S_DONE;
        end else if (w_expire) begin
          w_state_next = S_DONE;
        end
      end
      S_REQ1: begin
        o_mem_req  = 1'b1;
        o_mem_addr = w_base + 32'd4;
        if (i_mem_ack || w_expire) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_ld_done    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr       <= 32'h0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_cnt        <= '0;
      r_ld_data    <= 32'h0;
      r_ld_data_hi <= 32'h0;
      r_ld_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_ld_req) begin
            r_addr       <= i_ld_addr;
            r_size       <= i_ld_size;
            r_signed     <= i_ld_signed;
            r_cnt        <= '0;
            r_ld_data    <= 32'h0;
            r_ld_data_hi <= 32'h0;
            r_ld_err     <= w_misaligned;
          end
        end
        S_REQ0: begin
          if (i_mem_ack) begin
            r_ld_data <= w_ext;
            r_cnt     <= '0;
          end else if (w_expire) begin
            r_ld_err     <= 1'b1;
            r_ld_data    <= 32'h0;
            r_ld_data_hi <= 32'h0;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        S_REQ1: begin
          // A second-beat timeout also discards the already captured low word.
          if (i_mem_ack) begin
            r_ld_data_hi <= i_mem_rdata;
          end else if (w_expire) begin
            r_ld_err     <= 1'b1;
            r_ld_data    <= 32'h0;
            r_ld_data_hi <= 32'h0;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ld_busy    = (r_state != S_IDLE);
  assign o_ld_err     = r_ld_err;
  assign o_ld_data    = r_ld_data;
  assign o_ld_data_hi = r_ld_data_hi;

endmodule
